// File: rtl/led_responder.sv
// LED peripheral bus responder: LED data register, fixed wait-state response, error reporting.
// Optional hardware blink engine (PERIOD/CTRL/STATUS) built only when LED_RESPONDER_BLINK_EN is defined.
module led_responder #(
    parameter int               LED_W          = 8,
    parameter int               WAIT_STATES    = 1,
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(50_000_000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_led,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             err,
    output logic [LED_W-1:0] led_out
);

    // state  | meaning
    // S_IDLE | waiting for req && cs_led; access latched on acceptance
    // S_WAIT | counting WAIT_STATES cycles
    // S_RESP | ready strobe; writes commit at the end of this cycle
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int WS_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam int WS_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_t            r_state;
    state_t            w_next;
    logic [WS_W-1:0]   r_wcnt;
    logic              r_we;
    logic [3:0]        r_addr;
    logic [31:0]       r_wdata;
    logic [LED_W-1:0]  r_led;
    logic              w_err;
    logic              w_commit;
    logic              w_wr_led;
    logic              w_wr_period;
    logic              w_wr_ctrl;
    logic [31:0]       w_rmux;
    logic              w_unused;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req && cs_led) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT: if (r_wcnt == WS_W'(WS_LAST)) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_wcnt <= '0;
                if (req && cs_led) begin
                    r_we    <= we;
                    r_addr  <= addr[3:0];
                    r_wdata <= wdata;
                end
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + WS_W'(1);
            end
        end
    end

    assign w_err       = (r_addr[1:0] != 2'b00) || (r_we && (r_addr[3:2] == 2'b11));
    assign ready       = (r_state == S_RESP);
    assign err         = ready && w_err;
    assign rdata       = (ready && !w_err && !r_we) ? w_rmux : 32'h0;
    assign w_commit    = ready && r_we && !w_err;
    assign w_wr_led    = w_commit && (r_addr[3:2] == 2'b00);
    assign w_wr_period = w_commit && (r_addr[3:2] == 2'b01);
    assign w_wr_ctrl   = w_commit && (r_addr[3:2] == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_led <= '0;
        else if (w_wr_led) r_led <= r_wdata[LED_W-1:0];
    end

`ifdef LED_RESPONDER_BLINK_EN
    logic [CNT_W-1:0] r_period;
    logic             r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_active;

    assign w_active = r_ctrl && (r_period != '0);

    // Reconfiguring the blinker restarts it in the lit phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= DEFAULT_PERIOD;
            r_ctrl   <= 1'b0;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else begin
            if (w_wr_period) r_period <= r_wdata[CNT_W-1:0];
            if (w_wr_ctrl)   r_ctrl   <= r_wdata[0];
            if (w_wr_period || w_wr_ctrl) begin
                r_cnt   <= '0;
                r_phase <= 1'b1;
            end else if (w_active) begin
                if (r_cnt == r_period - CNT_W'(1)) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_rmux = 32'h0;
        case (r_addr[3:2])
            2'b00: w_rmux = 32'(r_led);
            2'b01: w_rmux = 32'(r_period);
            2'b10: w_rmux = {31'h0, r_ctrl};
            2'b11: w_rmux = {31'h0, r_phase};
            default: w_rmux = 32'h0;
        endcase
    end

    assign led_out  = (w_active && !r_phase) ? '0 : r_led;
    assign w_unused = &{1'b0, addr[31:4], r_wdata, DEFAULT_PERIOD};
`else
    always_comb begin
        w_rmux = 32'h0;
        if (r_addr[3:2] == 2'b00) w_rmux = 32'(r_led);
    end

    assign led_out  = r_led;
    assign w_unused = &{1'b0, addr[31:4], r_wdata, DEFAULT_PERIOD, w_wr_period, w_wr_ctrl};
`endif

endmodule

// File: doc/led_responder.md
Name: led_responder

Overview:
- Memory-mapped bus responder for the LED peripheral. It sits on the far side of the address decoder and serves accesses qualified by the decoder's cs_led select.
- Holds an LED data register and an optional hardware blink engine.
- Answers every access with a single-cycle ready pulse after a fixed number of wait states.
- Reports misaligned or illegal accesses with err.

Parameters:
- LED_W, 8, width of LED data register and led_out.
- WAIT_STATES, 1, number of cycles in the WAIT state before the response cycle (0 allowed).
- CNT_W, 24, width of blink period register and blink counter.
- DEFAULT_PERIOD, 24'd50_000_000 truncated to CNT_W, reset value of the PERIOD register.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs_led  input  1  chip select from the address decoder.
- req  input  1  access request, held by the requester until ready.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; only addr[3:0] is decoded here.
- wdata  input  32  write data.
- rdata  output  32  read data; valid only while ready=1, otherwise 0.
- ready  output  1  one-cycle response strobe.
- err  output  1  error flag; valid only while ready=1, otherwise 0.
- led_out  output  LED_W  drive to board LEDs.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; ready=0, err=0, rdata=0.
  - LED_DATA=0, PERIOD=DEFAULT_PERIOD, CTRL=0, blink counter=0, phase=1, led_out=0.
  - Reset mid-transaction aborts the transaction: no write, no ready.
- Register map (word offsets on addr[3:2]):
  - 0x0 LED_DATA, RW, LED_W bits, upper bits read 0.
  - 0x4 PERIOD, RW, CNT_W bits.
  - 0x8 CTRL, RW, bit0 = blink_en.
  - 0xC STATUS, RO, bit0 = phase.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on req && cs_led, latch we, addr[3:0] and wdata. Go to WAIT with wait counter=0 if WAIT_STATES>0, else go to RESP.
  - WAIT: count up. After exactly WAIT_STATES cycles, go to RESP.
  - RESP: ready=1 for one cycle; write committed at the end of this cycle; then go to IDLE.
- Latency: request sampled in cycle N gives ready in cycle N+1+WAIT_STATES.
- Handshake rules:
  - Requester drops req the cycle after ready.
  - req still high in IDLE is accepted as a new transaction, so there is at least one idle cycle between responses.
  - req or cs_led deasserting during WAIT does not cancel: the latched access completes.
  - req without cs_led in IDLE is ignored.
- Errors (ready=1, err=1, rdata=0, no state change):
  - addr[1:0] != 0.
  - write to STATUS.
- Blink engine:
  - Active when blink_en=1 and PERIOD!=0.
  - Counter increments each cycle. When counter == PERIOD-1, counter goes to 0 and phase toggles.
  - led_out = phase ? LED_DATA : 0 when active; led_out = LED_DATA otherwise.
  - PERIOD=0 with blink_en=1: no toggling, phase held at 1.
  - Any successful write to PERIOD or CTRL clears the counter to 0 and sets phase to 1, in the same cycle as the commit.
  - A LED_DATA write takes effect on led_out the cycle after RESP.

Optional Feature:
- Macro: LED_RESPONDER_BLINK_EN.
- Defined: blink engine, PERIOD, CTRL and STATUS behave as above.
- Not defined:
  - No counter or phase logic is built; led_out = LED_DATA always.
  - PERIOD, CTRL and STATUS read 0.
  - Writes to PERIOD/CTRL complete with err=0 and are discarded.
  - A write to STATUS still gives err=1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> led_out=0, ready=0, read PERIOD returns DEFAULT_PERIOD, read CTRL returns 0.
- Write latency, WAIT_STATES=1: req with we=1, addr=0x0, wdata=0xA5 sampled at cycle 10 -> ready=1, err=0 at cycle 12 only; led_out=0xA5 at cycle 13.
- Read-back: write PERIOD=4, then read addr=0x4 -> rdata=4 in the ready cycle, rdata=0 in the cycles before and after.
- Blink: LED_DATA=0xFF, PERIOD=4, CTRL=1 -> led_out alternates 0xFF for 4 cycles, then 0x00 for 4 cycles; STATUS bit0 tracks phase. Then set PERIOD=0 -> led_out stuck at 0xFF.
- Errors: write addr=0x2 -> ready=1, err=1, LED_DATA unchanged. Write addr=0xC -> err=1. A req with cs_led=0 for 5 cycles -> no ready.
- Robustness: drop cs_led during WAIT -> access still completes. Pulse rst_n low during WAIT of a LED_DATA write -> no ready, LED_DATA=0.
